// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: shift modes and FSM states.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_SHL = 2'b00,
        MODE_SHR = 2'b01,
        MODE_ROL = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-position shifter/rotator.
// USR_ASR_EN adds arith_i: SHR replicates the MSB instead of filling from ser_i.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d_i,
    input  mode_e            mode_i,
    input  logic             ser_i,
`ifdef USR_ASR_EN
    input  logic             arith_i,
`endif
    output logic [WIDTH-1:0] d_o,
    output logic             ser_o
);

    logic shr_fill;

    always_comb begin
`ifdef USR_ASR_EN
        shr_fill = arith_i ? d_i[WIDTH-1] : ser_i;
`else
        shr_fill = ser_i;
`endif
    end

    always_comb begin
        d_o   = d_i;
        ser_o = 1'b0;
        case (mode_i)
            MODE_SHL: begin
                d_o   = {d_i[WIDTH-2:0], ser_i};
                ser_o = d_i[WIDTH-1];
            end
            MODE_SHR: begin
                d_o   = {shr_fill, d_i[WIDTH-1:1]};
                ser_o = d_i[0];
            end
            MODE_ROL: begin
                d_o   = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
                ser_o = d_i[WIDTH-1];
            end
            MODE_ROR: begin
                d_o   = {d_i[0], d_i[WIDTH-1:1]};
                ser_o = d_i[0];
            end
            default: begin
                d_o   = d_i;
                ser_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus counted shift/rotate runs with busy/done.
// USR_ASR_EN adds the arith input for arithmetic shift-right runs.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] shift_cnt,
    input  logic             ser_in,
`ifdef USR_ASR_EN
    input  logic             arith,
`endif
    output logic [WIDTH-1:0] d_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    mode_e            mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             ser_q;
    logic             busy_q;
    logic             done_q;
`ifdef USR_ASR_EN
    logic             arith_q;
`endif

    logic [WIDTH-1:0] data_d;
    logic             ser_d;

    usr_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .d_i    (data_q),
        .mode_i (mode_q),
        .ser_i  (ser_in),
`ifdef USR_ASR_EN
        .arith_i(arith_q),
`endif
        .d_o    (data_d),
        .ser_o  (ser_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_SHL;
            cnt_q   <= '0;
            data_q  <= '0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef USR_ASR_EN
            arith_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        data_q <= d_in;
                    end else if (start) begin
                        if (shift_cnt == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            mode_q  <= mode_e'(mode);
                            cnt_q   <= shift_cnt;
                            busy_q  <= 1'b1;
                            state_q <= ST_SHIFT;
`ifdef USR_ASR_EN
                            arith_q <= arith;
`endif
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= data_d;
                    ser_q  <= ser_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    // Last shift of the run: leave busy and pulse done in the same edge.
                    if (cnt_q == CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign d_out   = data_q;
    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
